// File: rtl/chip8_mem_arbiter_if.sv
// rtl/chip8_mem_arbiter_if.sv - requester and memory port bundle for the CHIP-8 memory arbiter
interface chip8_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8
);
    // Processor requester
    logic                  proc_valid_in;
    logic [ADDR_WIDTH-1:0] proc_addr_in;
    logic                  proc_we_in;
    logic [DATA_WIDTH-1:0] proc_data_in;
    logic [1:0]            proc_type_in;
    logic                  proc_ready_out;
    logic                  proc_valid_out;

    // Video requester
    logic                  video_valid_in;
    logic [ADDR_WIDTH-1:0] video_addr_in;
    logic                  video_we_in;
    logic [DATA_WIDTH-1:0] video_data_in;
    logic [1:0]            video_type_in;
    logic                  video_ready_out;
    logic                  video_valid_out;

    // Debug requester
    logic                  debug_valid_in;
    logic [ADDR_WIDTH-1:0] debug_addr_in;
    logic                  debug_we_in;
    logic [DATA_WIDTH-1:0] debug_data_in;
    logic [1:0]            debug_type_in;
    logic                  debug_ready_out;
    logic                  debug_valid_out;

    // Shared response data
    logic [DATA_WIDTH-1:0] data_out;

    // Memory port
    logic                  mem_en_out;
    logic                  mem_we_out;
    logic [ADDR_WIDTH-1:0] mem_addr_out;
    logic [DATA_WIDTH-1:0] mem_data_out;
    logic [1:0]            mem_type_out;
    logic [DATA_WIDTH-1:0] mem_data_in;

    // Arbiter side
    modport slave (
        input  proc_valid_in, proc_addr_in, proc_we_in, proc_data_in, proc_type_in,
        input  video_valid_in, video_addr_in, video_we_in, video_data_in, video_type_in,
        input  debug_valid_in, debug_addr_in, debug_we_in, debug_data_in, debug_type_in,
        output proc_ready_out, proc_valid_out,
        output video_ready_out, video_valid_out,
        output debug_ready_out, debug_valid_out,
        output data_out,
        output mem_en_out, mem_we_out, mem_addr_out, mem_data_out, mem_type_out,
        input  mem_data_in
    );

    // Requester and memory side
    modport master (
        output proc_valid_in, proc_addr_in, proc_we_in, proc_data_in, proc_type_in,
        output video_valid_in, video_addr_in, video_we_in, video_data_in, video_type_in,
        output debug_valid_in, debug_addr_in, debug_we_in, debug_data_in, debug_type_in,
        input  proc_ready_out, proc_valid_out,
        input  video_ready_out, video_valid_out,
        input  debug_ready_out, debug_valid_out,
        input  data_out,
        input  mem_en_out, mem_we_out, mem_addr_out, mem_data_out, mem_type_out,
        output mem_data_in
    );
endinterface

// File: rtl/chip8_mem_arbiter.sv
// rtl/chip8_mem_arbiter.sv - round-robin arbiter sharing one CHIP-8 memory port among proc, video and debug
module chip8_mem_arbiter #(
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 8,
    parameter int READ_LATENCY = 2
) (
    input  logic               clk_in,
    input  logic               rst_in,
    chip8_mem_arbiter_if.slave bus
);
    localparam int         NREQ     = 3;
    localparam logic [2:0] CNT_LOAD = 3'(READ_LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            rr_ptr_q, rr_ptr_d;
    logic [1:0]            grant_q, grant_d;
    logic [2:0]            cnt_q, cnt_d;
    logic                  op_we_q, op_we_d;
    logic [NREQ-1:0]       ready_q, ready_d;
    logic [NREQ-1:0]       valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  mem_en_q, mem_en_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [1:0]            mem_type_q, mem_type_d;

    // Requester-indexed views: 0 = proc, 1 = video, 2 = debug
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_we;
    logic [ADDR_WIDTH-1:0] req_addr [NREQ];
    logic [DATA_WIDTH-1:0] req_data [NREQ];
    logic [1:0]            req_type [NREQ];

    assign req_valid = {bus.debug_valid_in, bus.video_valid_in, bus.proc_valid_in};
    assign req_we    = {bus.debug_we_in, bus.video_we_in, bus.proc_we_in};
    assign req_addr[0] = bus.proc_addr_in;
    assign req_addr[1] = bus.video_addr_in;
    assign req_addr[2] = bus.debug_addr_in;
    assign req_data[0] = bus.proc_data_in;
    assign req_data[1] = bus.video_data_in;
    assign req_data[2] = bus.debug_data_in;
    assign req_type[0] = bus.proc_type_in;
    assign req_type[1] = bus.video_type_in;
    assign req_type[2] = bus.debug_type_in;

    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    logic       pick_found;
    logic [1:0] pick_idx;

    // Find the first pending requester walking proc -> video -> debug from rr_ptr
    always_comb begin
        logic [1:0] cand;
        pick_found = 1'b0;
        pick_idx   = rr_ptr_q;
        cand       = rr_ptr_q;
        for (int k = 0; k < NREQ; k++) begin
            if (!pick_found && req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
            cand = rr_next(cand);
        end
    end

    // Transaction sequencing and next values of every registered output
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        cnt_d       = cnt_q;
        op_we_d     = op_we_q;
        ready_d     = '0;
        valid_d     = '0;
        data_d      = data_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_type_d  = mem_type_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    grant_d           = pick_idx;
                    op_we_d           = req_we[pick_idx];
                    mem_en_d          = 1'b1;
                    mem_we_d          = req_we[pick_idx];
                    mem_addr_d        = req_addr[pick_idx];
                    mem_wdata_d       = req_data[pick_idx];
                    mem_type_d        = req_type[pick_idx];
                    ready_d[pick_idx] = 1'b1;
                    state_d           = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = CNT_LOAD;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == 3'd0) begin
                    data_d           = op_we_q ? '0 : bus.mem_data_in;
                    valid_d[grant_q] = 1'b1;
                    state_d          = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_RESP: begin
                rr_ptr_d = rr_next(grant_q);
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset drops any transaction in flight
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= 2'd0;
            grant_q     <= 2'd0;
            cnt_q       <= 3'd0;
            op_we_q     <= 1'b0;
            ready_q     <= '0;
            valid_q     <= '0;
            data_q      <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_type_q  <= 2'd0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            cnt_q       <= cnt_d;
            op_we_q     <= op_we_d;
            ready_q     <= ready_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_type_q  <= mem_type_d;
        end
    end

    assign bus.proc_ready_out  = ready_q[0];
    assign bus.video_ready_out = ready_q[1];
    assign bus.debug_ready_out = ready_q[2];
    assign bus.proc_valid_out  = valid_q[0];
    assign bus.video_valid_out = valid_q[1];
    assign bus.debug_valid_out = valid_q[2];
    assign bus.data_out        = data_q;
    assign bus.mem_en_out      = mem_en_q;
    assign bus.mem_we_out      = mem_we_q;
    assign bus.mem_addr_out    = mem_addr_q;
    assign bus.mem_data_out    = mem_wdata_q;
    assign bus.mem_type_out    = mem_type_q;
endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// tb/tb_chip8_mem_arbiter.sv - self-checking bench for chip8_mem_arbiter
module tb_chip8_mem_arbiter;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic mem_init;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int unsigned mem_seed;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    chip8_mem_arbiter_if #(.ADDR_WIDTH(12), .DATA_WIDTH(8)) bus2 ();
    chip8_mem_arbiter_if #(.ADDR_WIDTH(12), .DATA_WIDTH(8)) bus1 ();
    chip8_mem_arbiter_if #(.ADDR_WIDTH(12), .DATA_WIDTH(8)) bus7 ();

    chip8_mem_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .READ_LATENCY(LAT)) u_dut (
        .clk_in(clk), .rst_in(rst_n), .bus(bus2));
    chip8_mem_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .READ_LATENCY(1)) u_dut_l1 (
        .clk_in(clk), .rst_in(rst_n), .bus(bus1));
    chip8_mem_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .READ_LATENCY(7)) u_dut_l7 (
        .clk_in(clk), .rst_in(rst_n), .bus(bus7));

    // Main requesters
    logic [2:0]  pend;
    logic [11:0] r_addr [3];
    logic [2:0]  r_we;
    logic [7:0]  r_data [3];
    logic [1:0]  r_type [3];

    assign bus2.proc_valid_in  = pend[0];
    assign bus2.proc_addr_in   = r_addr[0];
    assign bus2.proc_we_in     = r_we[0];
    assign bus2.proc_data_in   = r_data[0];
    assign bus2.proc_type_in   = r_type[0];
    assign bus2.video_valid_in = pend[1];
    assign bus2.video_addr_in  = r_addr[1];
    assign bus2.video_we_in    = r_we[1];
    assign bus2.video_data_in  = r_data[1];
    assign bus2.video_type_in  = r_type[1];
    assign bus2.debug_valid_in = pend[2];
    assign bus2.debug_addr_in  = r_addr[2];
    assign bus2.debug_we_in    = r_we[2];
    assign bus2.debug_data_in  = r_data[2];
    assign bus2.debug_type_in  = r_type[2];

    logic [2:0] ready_vec, valid_vec;
    assign ready_vec = {bus2.debug_ready_out, bus2.video_ready_out, bus2.proc_ready_out};
    assign valid_vec = {bus2.debug_valid_out, bus2.video_valid_out, bus2.proc_valid_out};

    // Latency-sweep instances: proc reads only
    logic [2:0]  sw_valid;
    logic [11:0] sw_addr [3];
    logic [2:0]  sw_ready, sw_vout;
    logic [7:0]  sw_dout [3];

    assign bus1.proc_valid_in = sw_valid[1];
    assign bus1.proc_addr_in  = sw_addr[1];
    assign bus7.proc_valid_in = sw_valid[2];
    assign bus7.proc_addr_in  = sw_addr[2];
    assign bus1.proc_we_in = 1'b0;  assign bus1.proc_data_in = 8'h00;  assign bus1.proc_type_in = 2'd0;
    assign bus7.proc_we_in = 1'b0;  assign bus7.proc_data_in = 8'h00;  assign bus7.proc_type_in = 2'd0;
    assign bus1.video_valid_in = 1'b0; assign bus1.video_addr_in = 12'h0; assign bus1.video_we_in = 1'b0;
    assign bus1.video_data_in = 8'h00; assign bus1.video_type_in = 2'd0;
    assign bus1.debug_valid_in = 1'b0; assign bus1.debug_addr_in = 12'h0; assign bus1.debug_we_in = 1'b0;
    assign bus1.debug_data_in = 8'h00; assign bus1.debug_type_in = 2'd0;
    assign bus7.video_valid_in = 1'b0; assign bus7.video_addr_in = 12'h0; assign bus7.video_we_in = 1'b0;
    assign bus7.video_data_in = 8'h00; assign bus7.video_type_in = 2'd0;
    assign bus7.debug_valid_in = 1'b0; assign bus7.debug_addr_in = 12'h0; assign bus7.debug_we_in = 1'b0;
    assign bus7.debug_data_in = 8'h00; assign bus7.debug_type_in = 2'd0;

    assign sw_ready = {bus7.proc_ready_out, bus1.proc_ready_out, 1'b0};
    assign sw_vout  = {bus7.proc_valid_out, bus1.proc_valid_out, 1'b0};
    assign sw_dout[0] = 8'h00;
    assign sw_dout[1] = bus1.data_out;
    assign sw_dout[2] = bus7.data_out;

    // Memory environment: one shared array, one read pipeline per instance
    logic [7:0]  bram [4096];
    logic [7:0]  ref_mem [4096];
    logic [7:0]  pipe [3][8];
    logic [2:0]  m_en;
    logic [11:0] m_addr [3];

    assign m_en      = {bus7.mem_en_out, bus1.mem_en_out, bus2.mem_en_out};
    assign m_addr[0] = bus2.mem_addr_out;
    assign m_addr[1] = bus1.mem_addr_out;
    assign m_addr[2] = bus7.mem_addr_out;
    assign bus2.mem_data_in = pipe[0][LAT-1];
    assign bus1.mem_data_in = pipe[1][0];
    assign bus7.mem_data_in = pipe[2][6];

    function automatic logic [7:0] init_val(input int i);
        if (i == 'h200) return 8'hA2;
        return 8'((i * 131) ^ (i >> 5) ^ int'(mem_seed));
    endfunction

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 4096; i++) bram[i] <= init_val(i);
        end else if (bus2.mem_en_out && bus2.mem_we_out) begin
            bram[bus2.mem_addr_out] <= bus2.mem_data_out;
        end
        for (int j = 0; j < 3; j++) begin
            if (m_en[j]) pipe[j][0] <= bram[m_addr[j]];
            for (int k = 1; k < 8; k++) pipe[j][k] <= pipe[j][k-1];
        end
    end

    // Reference model state
    int model_rr;
    int last_ready_cyc;
    bit have_prev;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic arm(input int i, input logic [11:0] a, input logic we,
                       input logic [7:0] d, input logic [1:0] t);
        r_addr[i] = a; r_we[i] = we; r_data[i] = d; r_type[i] = t; pend[i] = 1'b1;
    endtask

    task automatic arm_rand(input int i);
        logic [11:0] a;
        a = ($urandom_range(0, 1) == 1) ? (12'hF00 | 12'($urandom_range(0, 7))) : 12'($urandom);
        arm(i, a, 1'($urandom_range(0, 1)), 8'($urandom), 2'($urandom));
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_ready"}, 32'(ready_vec), 0);
        chk({tag, "_valid"}, 32'(valid_vec), 0);
        chk({tag, "_data"}, 32'(bus2.data_out), 0);
        chk({tag, "_mem_en"}, 32'(bus2.mem_en_out), 0);
        chk({tag, "_mem_we"}, 32'(bus2.mem_we_out), 0);
        chk({tag, "_mem_addr"}, 32'(bus2.mem_addr_out), 0);
        chk({tag, "_mem_wdata"}, 32'(bus2.mem_data_out), 0);
        chk({tag, "_mem_type"}, 32'(bus2.mem_type_out), 0);
    endtask

    // One transaction: predict the grantee from the round-robin rule, then follow it to its response
    task automatic serve(output int g);
        int got, waited;
        logic [7:0] exp_d;
        g = -1;
        for (int k = 0; k < 3; k++) begin
            if (g < 0 && pend[(model_rr + k) % 3]) g = (model_rr + k) % 3;
        end
        chk("serve_has_request", 32'(g >= 0), 1);
        if (g < 0) return;
        got = 0; waited = 0;
        while (got == 0 && waited < 30) begin
            @(negedge clk);
            if (ready_vec != 3'b000) got = 1;
            else begin
                waited++;
                chk("no_valid_before_grant", 32'(valid_vec), 0);
            end
        end
        chk("ready_seen", 32'(got), 1);
        if (got == 0) return;
        chk("ready_grant", 32'(ready_vec), 32'(1 << g));
        chk("mem_en_issue", 32'(bus2.mem_en_out), 1);
        chk("mem_we_issue", 32'(bus2.mem_we_out), 32'(r_we[g]));
        chk("mem_addr_issue", 32'(bus2.mem_addr_out), 32'(r_addr[g]));
        chk("mem_wdata_issue", 32'(bus2.mem_data_out), 32'(r_data[g]));
        chk("mem_type_issue", 32'(bus2.mem_type_out), 32'(r_type[g]));
        if (have_prev) chk("grant_spacing", 32'(cyc - last_ready_cyc), LAT + 3);
        last_ready_cyc = cyc;
        if (r_we[g]) begin
            exp_d = 8'h00;
            ref_mem[r_addr[g]] = r_data[g];
        end else begin
            exp_d = ref_mem[r_addr[g]];
        end
        pend[g] = 1'b0;
        for (int k = 1; k <= LAT + 1; k++) begin
            @(negedge clk);
            if (k <= LAT) begin
                chk("wait_no_valid", 32'(valid_vec), 0);
                chk("wait_no_ready", 32'(ready_vec), 0);
                chk("wait_no_mem_en", 32'(bus2.mem_en_out), 0);
            end
        end
        chk("valid_grant", 32'(valid_vec), 32'(1 << g));
        chk("data_out", 32'(bus2.data_out), 32'(exp_d));
        model_rr = (g + 1) % 3;
        have_prev = 1'b1;
    endtask

    task automatic sweep(input int j, input int lat);
        logic [11:0] a;
        int t_ready, t_valid;
        a = 12'($urandom);
        sw_addr[j] = a;
        sw_valid[j] = 1'b1;
        t_ready = -1; t_valid = -1;
        for (int n = 1; n <= 20 && t_valid < 0; n++) begin
            @(negedge clk);
            if (sw_ready[j] && t_ready < 0) begin
                t_ready = n;
                sw_valid[j] = 1'b0;
            end
            if (sw_vout[j]) t_valid = n;
        end
        sw_valid[j] = 1'b0;
        chk("sweep_ready_edge", 32'(t_ready), 1);
        chk("sweep_resp_edge", 32'(t_valid), 32'(lat + 2));
        chk("sweep_data", 32'(sw_dout[j]), 32'(ref_mem[a]));
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        mem_seed = $urandom;
        for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(i);
        pend = 3'b000; r_we = 3'b000; sw_valid = 3'b000;
        for (int i = 0; i < 3; i++) begin
            r_addr[i] = 12'h0; r_data[i] = 8'h00; r_type[i] = 2'd0; sw_addr[i] = 12'h0;
        end
        model_rr = 0; have_prev = 1'b0; last_ready_cyc = 0;
        rst_n = 1'b0;
        mem_init = 1'b1;
        @(negedge clk);
        mem_init = 1'b0;
        @(negedge clk);
        chk_zero_outputs("reset");
        rst_n = 1'b1;

        // Single read of the preloaded location
        arm(0, 12'h200, 1'b0, 8'h00, 2'd1);
        serve(g);
        chk("single_read_grant", 32'(g), 0);
        chk("single_read_data", 32'(bus2.data_out), 32'h0A2);

        // Video write, then debug read-back
        arm(1, 12'hF00, 1'b1, 8'hFF, 2'd2);
        serve(g);
        chk("write_grant", 32'(g), 1);
        arm(2, 12'hF00, 1'b0, 8'h00, 2'd3);
        serve(g);
        chk("readback_data", 32'(bus2.data_out), 32'h0FF);

        // Three-way contention held from reset, then rotation past video
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_rr = 0; have_prev = 1'b0;
        for (int i = 0; i < 3; i++) arm_rand(i);
        for (int n = 0; n < 4; n++) begin
            serve(g);
            chk("contention_order", 32'(g), 32'(n % 3));
            arm_rand(g);
        end
        serve(g);
        chk("rotation_video", 32'(g), 1);
        serve(g);
        chk("rotation_debug_first", 32'(g), 2);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 3; i++) if (!pend[i] && $urandom_range(0, 1) == 1) arm_rand(i);
            if (pend == 3'b000) arm_rand(int'($urandom_range(0, 2)));
            serve(g);
        end
        while (pend != 3'b000) serve(g);

        // Reset during WAIT abandons the read
        arm(0, 12'($urandom), 1'b0, 8'h00, 2'($urandom));
        begin
            int got;
            got = 0;
            for (int n = 0; n < 30 && got == 0; n++) begin
                @(negedge clk);
                if (ready_vec != 3'b000) got = 1;
            end
            chk("abandon_ready", 32'(ready_vec), 1);
        end
        pend[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk_zero_outputs("midreset");
        model_rr = 0; have_prev = 1'b0;
        for (int k = 0; k < LAT + 4; k++) begin
            @(negedge clk);
            chk("abandon_no_valid", 32'(valid_vec), 0);
        end
        arm_rand(0);
        arm_rand(1);
        serve(g);
        chk("after_reset_proc_first", 32'(g), 0);
        serve(g);
        chk("after_reset_video", 32'(g), 1);

        // Latency sweep on the READ_LATENCY=1 and =7 instances
        sweep(1, 1);
        sweep(1, 1);
        sweep(2, 7);
        sweep(2, 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
